mem_port_arbiter: RTL and testbench

- Sequences the core's single shared memory port between the instruction-fetch requester and the data (load/store) requester.
- Owns a small transaction FSM, grant priority with an anti-starvation counter, and fetch-flush handling.
- Drives per-requester stall outputs. These feed the bubble/stall logic in the hazard path.

---
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single memory port between instruction fetch and the
// load/store unit. One transaction is outstanding at a time; each grant is
// registered, so mem_* outputs stay stable until the memory acknowledges.
//
// Priority: data normally wins a contended grant. A streak counter tracks
// consecutive data grants made while fetch was also eligible. Once it reaches
// MAX_D_STREAK, fetch wins the next contended grant. A fetch redirect
// (if_flush_i) makes fetch ineligible in IDLE. During BUSY_IF it marks the
// in-flight fetch so its response is dropped. The bus transaction itself
// always runs to completion.
//
// Ports
//   clk, reset      core clock, asynchronous active-high reset
//   if_req_i        fetch request (level), if_addr_i fetch address
//   if_flush_i      fetch redirect; cancels pending/in-flight fetch response
//   if_rvalid_o     one-cycle pulse with if_rdata_o
//   if_stall_o      fetch requester must stall
//   d_req_i         data request (level), d_we_i store flag
//   d_addr_i        data address, d_wdata_i store data
//   d_rvalid_o      one-cycle pulse: load data valid / store done
//   d_rdata_o       load data
//   d_stall_o       data requester must stall
//   mem_req_o       memory transaction active
//   mem_we_o        write enable, mem_addr_o / mem_wdata_o registered
//   mem_ack_i       one-cycle completion pulse, mem_rdata_i valid with it
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              if_elig;
  logic              d_elig;

  // A requester whose response is being returned this cycle is still holding
  // its level request; masking with rvalid stops it from being regranted.
  assign if_elig = if_req_i & ~if_rvalid_q & ~if_flush_i;
  assign d_elig  = d_req_i & ~d_rvalid_q;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // Data wins unless fetch is also waiting and the streak is used up.
        // mem_ack_i is ignored here.
        if (d_elig && !(if_elig && (streak_q >= STREAK_MAX))) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          if (if_elig) begin
            streak_d = streak_q + STREAK_ONE;
          end
        end else if (if_elig) begin
          state_d    = ST_BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          streak_d   = '0;
        end
      end

      ST_BUSY_IF: begin
        if (if_flush_i) begin
          drop_d = 1'b1;
        end
        if (mem_ack_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A flush in the ack cycle itself also kills the response.
          if (!(drop_q || if_flush_i)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end

      ST_BUSY_D: begin
        if (mem_ack_i) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          d_rdata_d  = mem_rdata_i;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase

    // The streak only counts while fetch is actually asking.
    if (!if_req_i) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_stall_o  = if_req_i & ~if_rvalid_q;

  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_stall_o   = d_req_i & ~d_rvalid_q;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters, memory latency, flushes,
// spurious acks and asynchronous resets, all compared every cycle against a
// transaction-level model of the arbiter.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_i, if_flush_i, if_rvalid_o, if_stall_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i, d_rvalid_o, d_stall_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data) and what each
  // registered output must show.
  int            m_owner;
  bit            m_drop;
  int            m_streak;
  logic [AW-1:0] m_addr;
  bit            m_we;
  logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
  bit            m_if_rv, m_d_rv;

  // Memory responder configuration.
  int            lat_cfg;
  bit            mem_manual, ack_man, spur_en, rd_fixed, busy_seen;
  logic [DW-1:0] rd_val;
  int            wcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_drop = 0; m_streak = 0;
    m_addr = '0; m_we = 0; m_wdata = '0;
    m_if_rdata = '0; m_d_rdata = '0; m_if_rv = 0; m_d_rv = 0;
  endtask

  task automatic model_step();
    bit f_ok, d_ok;
    f_ok = if_req_i && !m_if_rv && !if_flush_i;
    d_ok = d_req_i && !m_d_rv;
    m_if_rv = 0;
    m_d_rv  = 0;
    case (m_owner)
      0: begin
        if (d_ok && !(f_ok && m_streak == MAXS)) begin
          m_owner = 2; m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i;
          if (f_ok) m_streak++;
        end else if (f_ok) begin
          m_owner = 1; m_addr = if_addr_i; m_we = 0; m_streak = 0;
        end
      end
      1: begin
        if (if_flush_i) m_drop = 1;
        if (mem_ack_i) begin
          if (!m_drop) begin m_if_rv = 1; m_if_rdata = mem_rdata_i; end
          m_drop = 0; m_owner = 0;
        end
      end
      2: begin
        if (mem_ack_i) begin
          m_d_rv = 1; m_d_rdata = mem_rdata_i; m_owner = 0;
        end
      end
      default: m_owner = 0;
    endcase
    if (!if_req_i) m_streak = 0;
  endtask

  task automatic compare_regs();
    chk("mem_req", mem_req_o, m_owner != 0);
    chk("mem_we", mem_we_o, m_we);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("if_rvalid", if_rvalid_o, m_if_rv);
    chk("d_rvalid", d_rvalid_o, m_d_rv);
    chk("if_rdata", if_rdata_o, m_if_rdata);
    chk("d_rdata", d_rdata_o, m_d_rdata);
  endtask

  task automatic drive_mem();
    if (mem_manual) begin
      mem_ack_i = ack_man;
    end else if (mem_req_o) begin
      if (!busy_seen) begin
        busy_seen = 1;
        wcnt = (lat_cfg < 0) ? $urandom_range(0, 3) : lat_cfg;
      end
      if (wcnt == 0) begin
        mem_ack_i = 1'b1; busy_seen = 0;
      end else begin
        mem_ack_i = 1'b0; wcnt--;
      end
    end else begin
      busy_seen = 0;
      mem_ack_i = spur_en && ($urandom_range(0, 15) == 0);
    end
    mem_rdata_i = rd_fixed ? rd_val : $urandom;
  endtask

  // Called at a falling edge with the cycle's requester inputs already set.
  task automatic do_cycle(input bit rst_pulse);
    drive_mem();
    #1;
    chk("if_stall", if_stall_o, if_req_i && !m_if_rv);
    chk("d_stall", d_stall_o, d_req_i && !m_d_rv);
    if (rst_pulse) begin
      reset = 1'b1;
      #1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_if_rvalid", if_rvalid_o, 0);
      chk("rst_d_rvalid", d_rvalid_o, 0);
      reset = 1'b0;
      model_reset();
    end
    model_step();
    @(negedge clk);
    compare_regs();
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
  endtask

  initial begin
    int n;
    bit got, got_d, got_if, seen;
    logic [AW-1:0] grants[$];
    logic [AW-1:0] exp_g[5];
    bit prev_req;

    idle_inputs();
    mem_ack_i = 0; mem_rdata_i = '0;
    lat_cfg = 0; mem_manual = 0; ack_man = 0; spur_en = 0;
    rd_fixed = 1; rd_val = '0; busy_seen = 0; wcnt = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    compare_regs();
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_d_rdata", d_rdata_o, 0);
    reset = 1'b0;
    do_cycle(0);

    // Single load, memory acks two cycles after mem_req_o.
    lat_cfg = 2; rd_val = 32'hDEADBEEF;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h40;
    do_cycle(0);
    chk("t1_mem_req", mem_req_o, 1);
    chk("t1_addr", mem_addr_o, 32'h40);
    chk("t1_we", mem_we_o, 0);
    n = 1; got = 0;
    while (!got && n < 12) begin
      do_cycle(0); n++;
      if (d_rvalid_o) got = 1;
    end
    chk("t1_got", got, 1);
    chk("t1_latency", n, 4);
    chk("t1_rdata", d_rdata_o, 32'hDEADBEEF);
    d_req_i = 0;
    do_cycle(0);
    chk("t1_single_pulse", d_rvalid_o, 0);

    // Store; request stays high through the response cycle.
    lat_cfg = 1;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h10; d_wdata_i = 32'h1234;
    do_cycle(0);
    chk("t2_we", mem_we_o, 1);
    chk("t2_wdata", mem_wdata_o, 32'h1234);
    chk("t2_addr", mem_addr_o, 32'h10);
    n = 0; got = 0;
    while (!got && n < 12) begin
      do_cycle(0); n++;
      if (d_rvalid_o) got = 1;
    end
    chk("t2_got", got, 1);
    do_cycle(0);
    chk("t2_no_regrant", mem_req_o, 0);
    d_req_i = 0; d_we_i = 0;
    do_cycle(0);

    // Contention with zero-wait memory. Flushing in each data-response
    // cycle keeps fetch out of that slot, so the streak limit decides.
    lat_cfg = 0; rd_val = 32'h11112222;
    if_req_i = 1; if_addr_i = 32'h300;
    d_req_i = 1; d_addr_i = 32'h500;
    exp_g = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h300};
    prev_req = mem_req_o;
    n = 0;
    while (grants.size() < 5 && n < 60) begin
      if_flush_i = m_d_rv;
      do_cycle(0); n++;
      if (mem_req_o && !prev_req) grants.push_back(mem_addr_o);
      prev_req = mem_req_o;
    end
    chk("t3_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("t3_grant_order", grants[i], exp_g[i]);
    if_flush_i = 0; d_req_i = 0;
    n = 0; got = 0;
    while (!got && n < 12) begin
      do_cycle(0); n++;
      if (if_rvalid_o) got = 1;
    end
    chk("t3_if_got", got, 1);
    chk("t3_if_rdata", if_rdata_o, 32'h11112222);
    if_req_i = 0;
    do_cycle(0);

    // Flush one cycle before the ack of an in-flight fetch.
    lat_cfg = 2; rd_val = 32'hAAAA5555;
    if_req_i = 1; if_addr_i = 32'h100;
    do_cycle(0);
    chk("t4_addr", mem_addr_o, 32'h100);
    chk("t4_we", mem_we_o, 0);
    seen = 0;
    do_cycle(0); seen |= if_rvalid_o;
    if_flush_i = 1;
    do_cycle(0); seen |= if_rvalid_o;
    if_flush_i = 0; if_req_i = 0;
    for (int i = 0; i < 4; i++) begin do_cycle(0); seen |= if_rvalid_o; end
    chk("t4_no_rvalid", seen, 0);
    chk("t4_rdata_kept", if_rdata_o, 32'h11112222);
    rd_val = 32'hCAFEF00D;
    if_req_i = 1; if_addr_i = 32'h200;
    n = 0; got = 0;
    while (!got && n < 12) begin
      do_cycle(0); n++;
      if (if_rvalid_o) got = 1;
    end
    chk("t4_next_got", got, 1);
    chk("t4_next_rdata", if_rdata_o, 32'hCAFEF00D);
    if_req_i = 0;
    do_cycle(0);

    // Flush in the ack cycle, then flush with a new fetch while data waits.
    lat_cfg = 1; rd_val = 32'h55;
    if_req_i = 1; if_addr_i = 32'h400;
    do_cycle(0);
    do_cycle(0);
    if_flush_i = 1;
    do_cycle(0);
    chk("t5_dropped", if_rvalid_o, 0);
    chk("t5_idle", mem_req_o, 0);
    if_addr_i = 32'h700; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h600;
    do_cycle(0);
    chk("t5_data_granted", mem_addr_o, 32'h600);
    chk("t5_data_req", mem_req_o, 1);
    if_flush_i = 0;
    got_d = 0; got_if = 0; n = 0;
    while (!(got_d && got_if) && n < 40) begin
      if (m_d_rv) d_req_i = 0;
      if (m_if_rv) if_req_i = 0;
      do_cycle(0); n++;
      got_d |= d_rvalid_o; got_if |= if_rvalid_o;
    end
    chk("t5_both_done", {got_d, got_if}, 2'b11);
    chk("t5_fetch_rdata", if_rdata_o, 32'h55);
    idle_inputs();
    do_cycle(0);

    // Reset during a data transaction, then a late ack.
    mem_manual = 1; ack_man = 0;
    d_req_i = 1; d_addr_i = 32'h800;
    do_cycle(0);
    chk("t6_busy", mem_req_o, 1);
    d_req_i = 0;
    do_cycle(1);
    chk("t6_after_rst", mem_req_o, 0);
    ack_man = 1;
    do_cycle(0);
    ack_man = 0;
    chk("t6_late_ack_d", d_rvalid_o, 0);
    chk("t6_late_ack_if", if_rvalid_o, 0);
    chk("t6_still_idle", mem_req_o, 0);
    do_cycle(0);
    mem_manual = 0;

    // Randomized traffic.
    lat_cfg = -1; spur_en = 1; rd_fixed = 0;
    for (int c = 0; c < 4000; c++) begin
      bit fl;
      fl = ($urandom_range(0, 3) == 0);
      if (!if_req_i || m_if_rv || fl) begin
        if_req_i = ($urandom_range(0, 3) != 0);
        if_addr_i = $urandom;
      end
      if_flush_i = fl;
      if (!d_req_i || m_d_rv) begin
        d_req_i = ($urandom_range(0, 3) != 0);
        d_we_i = $urandom_range(0, 1);
        d_addr_i = $urandom;
        d_wdata_i = $urandom;
      end
      do_cycle($urandom_range(0, 249) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
